// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA timing defaults and axis-window helpers.
// Revision: 1.0
`default_nettype none

package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync window is inclusive on both ends so it never needs COORD_MAX itself.
  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one timing axis: wrapping counter plus next-state window decode.
// Revision: 1.0
`default_nettype none

module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap_next,
  output logic               sync_next,
  output logic               active_next
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_MAX);
  end
  if (ACTIVE < 1 || SYNC < 1) begin : g_bad_window
    $error("vga_axis_counter: ACTIVE and SYNC must be at least 1");
  end

  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_LAST = COORD_W'(ACTIVE - 1);
  localparam logic [COORD_W-1:0] SYNC_LO  = COORD_W'(sync_first(ACTIVE, FP));
  localparam logic [COORD_W-1:0] SYNC_HI  = COORD_W'(sync_last(ACTIVE, FP, SYNC));

  logic [COORD_W-1:0] cnt_next;

  // wrap_next flags that the next enabled advance returns the axis to zero.
  assign wrap_next = (cnt == LAST);

  always_comb begin
    cnt_next = cnt;
    if (en) begin
      cnt_next = wrap_next ? '0 : cnt + COORD_W'(1);
    end
  end

  // Decoding the upcoming count lets the top register outputs aligned with cnt.
  assign sync_next   = (cnt_next >= SYNC_LO) && (cnt_next <= SYNC_HI);
  assign active_next = (cnt_next <= ACT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- registered 640x480@60 VGA timing with line/frame strobes.
// Revision: 1.0
`default_nettype none

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  logic h_wrap, h_sync, h_act;
  logic v_wrap, v_sync, v_act;
  logic v_en;

  // The vertical axis steps on exactly the advance that wraps x.
  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .en          (pix_en),
    .cnt         (x),
    .wrap_next   (h_wrap),
    .sync_next   (h_sync),
    .active_next (h_act)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .en          (v_en),
    .cnt         (y),
    .wrap_next   (v_wrap),
    .sync_next   (v_sync),
    .active_next (v_act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
      if (pix_en) begin
        hsync    <= h_sync ? SYNC_POL : ~SYNC_POL;
        vsync    <= v_sync ? SYNC_POL : ~SYNC_POL;
        video_on <= h_act & v_act;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- random-stimulus check of default and shrunken VGA timing against a frame-position model.
// Revision: 1.0
`default_nettype none

module tb_vga_sync_gen;

  localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VA = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
  localparam int S_HA = 16,  S_HFP = 2,  S_HS = 4,  S_HBP = 2;
  localparam int S_VA = 4,   S_VFP = 1,  S_VS = 1,  S_VBP = 1;
  localparam int D_HT = D_HA + D_HFP + D_HS + D_HBP;
  localparam int D_N  = D_HT * (D_VA + D_VFP + D_VS + D_VBP);
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_N  = S_HT * (S_VA + S_VFP + S_VS + S_VBP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_dut_dflt (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
    .x(d_x), .y(d_y), .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b1)
  ) u_dut_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pos_d = 0, pos_s = 0;
  bit ls_d = 0, fs_d = 0, ls_s = 0, fs_s = 0;
  int last_ls_d = -1, last_fs_s = -1;
  int exp_ls_per = 0, exp_fs_per = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs from a linear frame position: {x, y, hsync, vsync, video_on, line_start, frame_start}.
  function automatic logic [24:0] model_out(input int pos, input bit ls, input bit fs,
                                            input int ha, input int hfp, input int hs, input int hbp,
                                            input int va, input int vfp, input int vs, input bit pol);
    int ht, xx, yy;
    bit h_on, v_on, vid;
    ht   = ha + hfp + hs + hbp;
    xx   = pos % ht;
    yy   = pos / ht;
    h_on = (xx >= ha + hfp) && (xx < ha + hfp + hs);
    v_on = (yy >= va + vfp) && (yy < va + vfp + vs);
    vid  = (xx < ha) && (yy < va);
    return {xx[9:0], yy[9:0], h_on ? pol : ~pol, v_on ? pol : ~pol, vid, ls, fs};
  endfunction

  task automatic step(input bit r, input bit e);
    logic [24:0] ed, es;
    rst    = r;
    pix_en = e;
    @(posedge clk);
    cyc++;
    if (r) begin
      pos_d = D_N - 1; pos_s = S_N - 1;
      ls_d = 0; fs_d = 0; ls_s = 0; fs_s = 0;
      last_ls_d = -1; last_fs_s = -1;
    end else if (e) begin
      pos_d = (pos_d + 1) % D_N;
      pos_s = (pos_s + 1) % S_N;
      ls_d = (pos_d % D_HT) == 0; fs_d = (pos_d == 0);
      ls_s = (pos_s % S_HT) == 0; fs_s = (pos_s == 0);
    end else begin
      ls_d = 0; fs_d = 0; ls_s = 0; fs_s = 0;
    end
    @(negedge clk);
    ed = model_out(pos_d, ls_d, fs_d, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, 1'b0);
    es = model_out(pos_s, ls_s, fs_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, 1'b1);
    chk("d_xy",   {d_x, d_y}, ed[24:5]);
    chk("d_sync", {d_hsync, d_vsync, d_video_on}, ed[4:2]);
    chk("d_strb", {d_line_start, d_frame_start}, ed[1:0]);
    chk("s_xy",   {s_x, s_y}, es[24:5]);
    chk("s_sync", {s_hsync, s_vsync, s_video_on}, es[4:2]);
    chk("s_strb", {s_line_start, s_frame_start}, es[1:0]);
    if (d_line_start) begin
      if (exp_ls_per != 0 && last_ls_d >= 0) chk("d_line_period", cyc - last_ls_d, exp_ls_per);
      last_ls_d = cyc;
    end
    if (s_frame_start) begin
      if (exp_fs_per != 0 && last_fs_s >= 0) chk("s_frame_period", cyc - last_fs_s, exp_fs_per);
      last_fs_s = cyc;
    end
  endtask

  initial begin
    int hs_cnt, vid_cnt, hs_min, hs_max;
    int svs_cnt, svid_cnt, shs_min, shs_max;
    int guard;

    // Reset held with pix_en high must dominate.
    repeat (3) step(1'b1, 1'b1);
    chk("rst_x", d_x, 799);
    chk("rst_y", d_y, 524);
    chk("rst_flags", {d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start}, 5'b11000);
    chk("rst_small_flags", {s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start}, 5'b00000);
    step(1'b0, 1'b1);
    chk("first_xy", {d_x, d_y}, 20'd0);
    chk("first_flags", {d_video_on, d_line_start, d_frame_start}, 3'b111);

    // One full default line and one full small frame at full rate.
    hs_cnt = 0; vid_cnt = 0; hs_min = 9999; hs_max = -1;
    svs_cnt = 0; svid_cnt = 0; shs_min = 9999; shs_max = -1;
    for (int i = 0; i < 800; i++) begin
      if (!d_hsync) begin
        hs_cnt++;
        if (int'(d_x) < hs_min) hs_min = int'(d_x);
        if (int'(d_x) > hs_max) hs_max = int'(d_x);
      end
      if (d_video_on) vid_cnt++;
      if (i < S_N) begin
        if (s_vsync) svs_cnt++;
        if (s_video_on) svid_cnt++;
        if (s_hsync) begin
          if (int'(s_x) < shs_min) shs_min = int'(s_x);
          if (int'(s_x) > shs_max) shs_max = int'(s_x);
        end
      end
      step(1'b0, 1'b1);
    end
    chk("hsync_low_cycles", hs_cnt, 96);
    chk("hsync_first_x", hs_min, 656);
    chk("hsync_last_x", hs_max, 751);
    chk("video_cycles", vid_cnt, 640);
    chk("s_vsync_cycles", svs_cnt, 24);
    chk("s_video_cycles", svid_cnt, 64);
    chk("s_hsync_first_x", shs_min, 18);
    chk("s_hsync_last_x", shs_max, 21);

    exp_ls_per = 800; exp_fs_per = 168;
    last_ls_d = -1; last_fs_s = -1;
    repeat (1200) step(1'b0, 1'b1);

    // Enable at one clock in four.
    exp_ls_per = 3200; exp_fs_per = 672;
    last_ls_d = -1; last_fs_s = -1;
    for (int k = 0; k < 8000; k++) step(1'b0, (k % 4) == 0);

    // Reset in the middle of a line.
    exp_ls_per = 0; exp_fs_per = 0;
    guard = 0;
    while (d_x != 10'd300 && guard < 2000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("reach_x300", {31'd0, guard < 2000}, 32'd1);
    step(1'b1, 1'b0);
    chk("mid_rst_xy", {d_x, d_y}, {10'd799, 10'd524});
    chk("mid_rst_flags", {d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start}, 5'b11000);
    chk("mid_rst_small_xy", {s_x, s_y}, {10'd23, 10'd6});
    step(1'b0, 1'b1);
    chk("mid_rst_restart", {d_x, d_y, d_frame_start, d_line_start}, {20'd0, 2'b11});

    // Random enables with rare resets.
    for (int k = 0; k < 20000; k++) step(($urandom % 400) == 0, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Downstream consumer of the clock divider's 25 MHz pixel clock.
- Generates 640x480@60 Hz VGA timing: hsync, vsync, video_on and the current pixel coordinates.
- Also produces frame and line strobes; the snake renderer and the game-tick logic use them to sample state only during blanking.
- All outputs are registered; counters advance only on pix_en.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock (25 MHz divider output, or 100 MHz with pix_en strobe)
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel advance enable; tie 1 when clk is the 25 MHz pixel clock
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
video_on  out  1  high while (x,y) is inside the active area
x  out  10  current horizontal count, 0..H_TOTAL-1
y  out  10  current vertical count, 0..V_TOTAL-1
line_start  out  1  one-cycle pulse when x wraps to 0
frame_start  out  1  one-cycle pulse when (x,y) wraps to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be <= 1024; elaboration fails otherwise.
- Reset (rst=1 at a clk edge), state on the next cycle:
  - x=H_TOTAL-1 (799), y=V_TOTAL-1 (524).
  - video_on=0; hsync=vsync=inactive (~SYNC_POL).
  - line_start=frame_start=0.
  - Reset dominates pix_en.
- Reset mid-frame: same result, applied on the next edge. There is no partial-line completion.
- Advance on a clk edge with pix_en=1, rst=0:
  - x <= (x==H_TOTAL-1) ? 0 : x+1.
  - y advances only when x wraps: y <= (y==V_TOTAL-1) ? 0 : y+1.
- pix_en=0: x, y, hsync, vsync and video_on hold; line_start=frame_start=0.
- Decoding is from the next-state counters, so every output in a cycle refers to the same (x,y) with zero skew:
  - video_on = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - vsync depends on y only; it changes in the same cycle x wraps to 0.
- Strobes:
  - line_start=1 for exactly the one cycle following an advance that sets x=0.
  - frame_start=1 for exactly the one cycle following an advance that sets (x,y)=(0,0); line_start is also 1 in that cycle.
- The first pix_en after reset produces (0,0) with frame_start=1, line_start=1, video_on=1.
- Rates at pix_en=1, 25 MHz:
  - line_start every 800 cycles.
  - frame_start every 420000 cycles.
- No combinational path from inputs to outputs.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_*/V_*);
  - H_TOTAL/V_TOTAL derivation;
  - sync-window bounds as functions of the parameters;
  - the 10-bit coordinate width constant.
- Sub-module vga_axis_counter, parameterised by ACTIVE/FP/SYNC/BP:
  - inputs: clk, rst, en; outputs: cnt, wrap_next, sync_next, active_next.
  - Instantiated twice: horizontal with en=pix_en; vertical with en=pix_en & h.wrap_next.
- Top level registers the outputs and the strobes.

Test Plan:
- Reset check: assert rst 3 cycles with pix_en=1 -> x=799, y=524, video_on=0, hsync=vsync=1, strobes 0; first advance after release -> x=0, y=0, video_on=1, frame_start=1, line_start=1.
- Horizontal timing: pix_en=1 for one line -> hsync low exactly for x=656..751 (96 cycles); video_on high for x=0..639; line_start period 800 cycles.
- Vertical/frame timing: run 2 full frames -> vsync low for y=490..491 (1600 cycles); video_on=0 for all y>=480; frame_start spacing exactly 420000 cycles.
- Enable gating: pix_en pulsed 1-in-4 at 100 MHz -> x advances once per 4 clk cycles; outputs hold in between; strobes last exactly one clk cycle; frame spacing is 1680000 cycles.
- Reset mid-frame: rst at x=300, y=200 -> next cycle x=799, y=524, all outputs at reset values; next advance gives frame_start=1.
- Parameter override: H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=1 -> H_TOTAL=24, V_TOTAL=7; hsync high for x=18..21; vsync high for y=5; frame period 168 cycles.
